alu_rs: RTL and testbench

- Reservation station for the ALU, directly downstream of the register file and dispatcher.
- Captures dispatched instructions together with operand data/tag pairs read from the register file.
- Snoops the ALU and LS result buses for outstanding tags and wakes waiting operands.
- Issues one fully-ready instruction per cycle to the ALU over a valid/ready handshake.

---
 rtl/alu_rs.sv | 134 +++++++++++++
 tb/tb_alu_rs.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// ALU reservation station. It holds dispatched instructions, wakes their operands from the
// ALU and LS result buses, and issues the lowest-index fully-ready slot to the ALU.
module alu_rs #(
    parameter int ENTRIES  = 8,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4,
    parameter int NAME_W   = 5,
    parameter int OP_W     = 6,
    parameter int TAG_FREE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_en,
    input  logic [OP_W-1:0]   disp_op,
    input  logic [DATA_W-1:0] disp_data_o,
    input  logic [TAG_W-1:0]  disp_tag_o,
    input  logic [DATA_W-1:0] disp_data_t,
    input  logic [TAG_W-1:0]  disp_tag_t,
    input  logic [NAME_W-1:0] disp_dest_name,
    input  logic [TAG_W-1:0]  disp_dest_tag,
    output logic              rs_full,
    input  logic              alu_wrt_en,
    input  logic [TAG_W-1:0]  alu_wrt_tag,
    input  logic [DATA_W-1:0] alu_wrt_data,
    input  logic              ls_wrt_en,
    input  logic [TAG_W-1:0]  ls_wrt_tag,
    input  logic [DATA_W-1:0] ls_wrt_data,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [OP_W-1:0]   issue_op,
    output logic [DATA_W-1:0] issue_src_o,
    output logic [DATA_W-1:0] issue_src_t,
    output logic [NAME_W-1:0] issue_dest_name,
    output logic [TAG_W-1:0]  issue_dest_tag
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [TAG_W-1:0] FREE = TAG_W'(TAG_FREE);

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  tag_o;
        logic [DATA_W-1:0] data_o;
        logic [TAG_W-1:0]  tag_t;
        logic [DATA_W-1:0] data_t;
        logic [NAME_W-1:0] dname;
        logic [TAG_W-1:0]  dtag;
    } slot_t;

    slot_t              slot_q [ENTRIES];
    slot_t              slot_d [ENTRIES];
    logic [ENTRIES-1:0] vld;
    logic [ENTRIES-1:0] rdy;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   sel_idx;

    // A free operand never matches, so a broadcast carrying TAG_FREE is ignored naturally.
    function automatic logic [TAG_W+DATA_W-1:0] snoop(input logic [TAG_W-1:0]  tag,
                                                       input logic [DATA_W-1:0] data);
        if (tag != FREE && alu_wrt_en && alu_wrt_tag == tag) return {FREE, alu_wrt_data};
        if (tag != FREE && ls_wrt_en && ls_wrt_tag == tag)   return {FREE, ls_wrt_data};
        return {tag, data};
    endfunction

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            vld[i] = slot_q[i].valid;
            rdy[i] = slot_q[i].valid && slot_q[i].tag_o == FREE && slot_q[i].tag_t == FREE;
        end
    end

    assign rs_full = &vld;

    // Descending scan leaves the lowest matching index in each encoder.
    always_comb begin
        free_idx    = '0;
        sel_idx     = '0;
        issue_valid = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!vld[i]) free_idx = IDX_W'(i);
            if (rdy[i]) begin
                sel_idx     = IDX_W'(i);
                issue_valid = 1'b1;
            end
        end
    end

    always_comb begin
        issue_op        = '0;
        issue_src_o     = '0;
        issue_src_t     = '0;
        issue_dest_name = '0;
        issue_dest_tag  = '0;
        if (issue_valid) begin
            issue_op        = slot_q[sel_idx].op;
            issue_src_o     = slot_q[sel_idx].data_o;
            issue_src_t     = slot_q[sel_idx].data_t;
            issue_dest_name = slot_q[sel_idx].dname;
            issue_dest_tag  = slot_q[sel_idx].dtag;
        end
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            slot_d[i] = slot_q[i];
            if (slot_q[i].valid) begin
                {slot_d[i].tag_o, slot_d[i].data_o} = snoop(slot_q[i].tag_o, slot_q[i].data_o);
                {slot_d[i].tag_t, slot_d[i].data_t} = snoop(slot_q[i].tag_t, slot_q[i].data_t);
            end
        end
        if (issue_valid && issue_ready) slot_d[sel_idx].valid = 1'b0;
        // The issued slot is still valid this cycle, so it can never be the free slot.
        if (disp_en && !rs_full) begin
            slot_d[free_idx].valid = 1'b1;
            slot_d[free_idx].op    = disp_op;
            slot_d[free_idx].dname = disp_dest_name;
            slot_d[free_idx].dtag  = disp_dest_tag;
            {slot_d[free_idx].tag_o, slot_d[free_idx].data_o} = snoop(disp_tag_o, disp_data_o);
            {slot_d[free_idx].tag_t, slot_d[free_idx].data_t} = snoop(disp_tag_t, disp_data_t);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) slot_q[i] <= slot_d[i];
        end
    end

    a_no_disp_when_full: assert property (@(posedge clk) disable iff (!rst) !(disp_en && rs_full))
        else $error("alu_rs: dispatch while full");

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios plus random traffic, all compared against a
// slot-array reference model updated once per clock.
module tb_alu_rs;
    localparam int E = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_en;
    logic [5:0]  disp_op;
    logic [31:0] disp_data_o, disp_data_t;
    logic [3:0]  disp_tag_o, disp_tag_t, disp_dest_tag;
    logic [4:0]  disp_dest_name;
    logic        rs_full;
    logic        alu_wrt_en, ls_wrt_en;
    logic [3:0]  alu_wrt_tag, ls_wrt_tag;
    logic [31:0] alu_wrt_data, ls_wrt_data;
    logic        issue_valid, issue_ready;
    logic [5:0]  issue_op;
    logic [31:0] issue_src_o, issue_src_t;
    logic [4:0]  issue_dest_name;
    logic [3:0]  issue_dest_tag;

    alu_rs dut (
        .clk(clk), .rst(rst), .disp_en(disp_en), .disp_op(disp_op),
        .disp_data_o(disp_data_o), .disp_tag_o(disp_tag_o),
        .disp_data_t(disp_data_t), .disp_tag_t(disp_tag_t),
        .disp_dest_name(disp_dest_name), .disp_dest_tag(disp_dest_tag), .rs_full(rs_full),
        .alu_wrt_en(alu_wrt_en), .alu_wrt_tag(alu_wrt_tag), .alu_wrt_data(alu_wrt_data),
        .ls_wrt_en(ls_wrt_en), .ls_wrt_tag(ls_wrt_tag), .ls_wrt_data(ls_wrt_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_src_o(issue_src_o), .issue_src_t(issue_src_t),
        .issue_dest_name(issue_dest_name), .issue_dest_tag(issue_dest_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [5:0]  op;
        logic [3:0]  tag_o;
        logic [31:0] val_o;
        logic [3:0]  tag_t;
        logic [31:0] val_t;
        logic [4:0]  dn;
        logic [3:0]  dt;
    } ent_t;

    ent_t m [E];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void snoop(inout logic [3:0] t, inout logic [31:0] d);
        if (t != 0) begin
            if (alu_wrt_en && alu_wrt_tag == t) begin d = alu_wrt_data; t = 0; end
            else if (ls_wrt_en && ls_wrt_tag == t) begin d = ls_wrt_data; t = 0; end
        end
    endfunction

    function automatic bit m_full();
        for (int i = 0; i < E; i++) if (!m[i].v) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_sel();
        for (int i = 0; i < E; i++) if (m[i].v && m[i].tag_o == 0 && m[i].tag_t == 0) return i;
        return -1;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < E; i++) m[i] = '{default: 0};
    endtask

    task automatic idle();
        disp_en = 0; alu_wrt_en = 0; ls_wrt_en = 0;
    endtask

    task automatic disp(input int op, input int to, input int dvo, input int tt, input int dvt,
                        input int dn, input int dt);
        disp_en = 1; disp_op = 6'(op); disp_tag_o = 4'(to); disp_data_o = 32'(dvo);
        disp_tag_t = 4'(tt); disp_data_t = 32'(dvt); disp_dest_name = 5'(dn); disp_dest_tag = 4'(dt);
    endtask

    // Called at a falling edge with inputs set: check outputs, clock once, advance the model.
    task automatic tick();
        int   s;
        bit   full;
        ent_t nm [E];
        logic [3:0]  t;
        logic [31:0] d;
        s = m_sel();
        full = m_full();
        chk("rs_full", 64'(rs_full), 64'(full));
        chk("issue_valid", 64'(issue_valid), 64'(s >= 0));
        if (s >= 0) begin
            chk("issue_op", 64'(issue_op), 64'(m[s].op));
            chk("issue_src_o", 64'(issue_src_o), 64'(m[s].val_o));
            chk("issue_src_t", 64'(issue_src_t), 64'(m[s].val_t));
            chk("issue_dest_name", 64'(issue_dest_name), 64'(m[s].dn));
            chk("issue_dest_tag", 64'(issue_dest_tag), 64'(m[s].dt));
        end else begin
            chk("idle_outputs_zero",
                64'(|{issue_op, issue_src_o, issue_src_t, issue_dest_name, issue_dest_tag}), 64'(0));
        end
        @(posedge clk);
        nm = m;
        if (s >= 0 && issue_ready) nm[s].v = 0;
        for (int i = 0; i < E; i++) begin
            if (m[i].v) begin
                t = m[i].tag_o; d = m[i].val_o; snoop(t, d); nm[i].tag_o = t; nm[i].val_o = d;
                t = m[i].tag_t; d = m[i].val_t; snoop(t, d); nm[i].tag_t = t; nm[i].val_t = d;
            end
        end
        if (disp_en && !full) begin
            for (int i = 0; i < E; i++) begin
                if (!m[i].v) begin
                    nm[i].v = 1; nm[i].op = disp_op; nm[i].dn = disp_dest_name; nm[i].dt = disp_dest_tag;
                    t = disp_tag_o; d = disp_data_o; snoop(t, d); nm[i].tag_o = t; nm[i].val_o = d;
                    t = disp_tag_t; d = disp_data_t; snoop(t, d); nm[i].tag_t = t; nm[i].val_t = d;
                    break;
                end
            end
        end
        m = nm;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 0;
        m_clear();
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        rst = 0; issue_ready = 0;
        disp_op = 0; disp_data_o = 0; disp_tag_o = 0; disp_data_t = 0; disp_tag_t = 0;
        disp_dest_name = 0; disp_dest_tag = 0;
        alu_wrt_tag = 0; alu_wrt_data = 0; ls_wrt_tag = 0; ls_wrt_data = 0;
        idle();
        m_clear();
        #12;
        chk("reset_rs_full", 64'(rs_full), 0);
        chk("reset_issue_valid", 64'(issue_valid), 0);
        chk("reset_issue_data", 64'(|{issue_op, issue_src_o, issue_src_t, issue_dest_tag}), 0);
        @(negedge clk);
        rst = 1;

        // ready dispatch issues the very next cycle, then the station is empty again
        issue_ready = 1;
        disp(3, 0, 5, 0, 7, 1, 2); tick(); idle();
        chk("ready_valid", 64'(issue_valid), 1);
        chk("ready_src_o", 64'(issue_src_o), 5);
        chk("ready_src_t", 64'(issue_src_t), 7);
        chk("ready_dest_tag", 64'(issue_dest_tag), 2);
        tick();
        chk("ready_drained", 64'(issue_valid), 0);
        tick();

        // wakeup from the ALU bus
        disp(1, 4, 0, 0, 9, 2, 3); tick(); idle();
        chk("wait_not_ready", 64'(issue_valid), 0);
        alu_wrt_en = 1; alu_wrt_tag = 4; alu_wrt_data = 32'h1234; tick(); idle();
        chk("wake_valid", 64'(issue_valid), 1);
        chk("wake_src_o", 64'(issue_src_o), 32'h1234);
        tick(); tick();

        // same-cycle capture from the LS bus at dispatch
        disp(2, 0, 1, 6, 0, 3, 4); ls_wrt_en = 1; ls_wrt_tag = 6; ls_wrt_data = 32'hAA; tick(); idle();
        chk("capture_valid", 64'(issue_valid), 1);
        chk("capture_src_t", 64'(issue_src_t), 32'hAA);
        tick(); tick();

        // both buses wake different operands of one slot in the same cycle
        disp(4, 1, 0, 2, 0, 4, 5); tick(); idle();
        alu_wrt_en = 1; alu_wrt_tag = 1; alu_wrt_data = 10;
        ls_wrt_en = 1; ls_wrt_tag = 2; ls_wrt_data = 20; tick(); idle();
        chk("dual_src_o", 64'(issue_src_o), 10);
        chk("dual_src_t", 64'(issue_src_t), 20);
        tick(); tick();

        // fill under backpressure, then drain in index order
        issue_ready = 0;
        for (int k = 0; k < E; k++) begin disp(k, 0, k, 0, k + 100, k, k); tick(); end
        idle();
        chk("full_after_8", 64'(rs_full), 1);
        tick();
        issue_ready = 1;
        for (int k = 0; k < E; k++) begin
            chk("drain_order", 64'(issue_dest_tag), 64'(k));
            if (k == 0) chk("full_during_first_accept", 64'(rs_full), 1);
            if (k == 1) chk("full_drops_after_accept", 64'(rs_full), 0);
            tick();
        end
        chk("drained", 64'(issue_valid), 0);

        // asynchronous reset between edges with live entries
        issue_ready = 0;
        for (int k = 0; k < 3; k++) begin disp(k + 1, 0, k, 0, k, k, k + 1); tick(); end
        idle();
        chk("pre_reset_valid", 64'(issue_valid), 1);
        #2 rst = 0;
        #1;
        chk("async_reset_valid", 64'(issue_valid), 0);
        chk("async_reset_full", 64'(rs_full), 0);
        m_clear();
        @(negedge clk);
        rst = 1;
        disp(9, 0, 1, 0, 2, 1, 1); tick(); idle();
        chk("post_reset_slot0", 64'(dut.slot_q[0].valid), 1);
        tick();
        do_reset();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            issue_ready = ($urandom_range(0, 3) != 0);
            disp_en = 0;
            if (!m_full() && $urandom_range(0, 1) == 1)
                disp($urandom_range(0, 63),
                     ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, 7), $urandom,
                     ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, 7), $urandom,
                     $urandom_range(0, 31), $urandom_range(0, 15));
            alu_wrt_en = ($urandom_range(0, 2) == 0); alu_wrt_tag = 4'($urandom_range(0, 7));
            alu_wrt_data = $urandom;
            ls_wrt_en = ($urandom_range(0, 2) == 0); ls_wrt_tag = 4'($urandom_range(0, 7));
            ls_wrt_data = $urandom;
            tick();
        end
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
